// File: rtl/crtc_timing.sv
// 6545-class CRTC timing core: sync, display enable, MA/RA and cursor
// generation from a 16-entry register file, advanced per character clock.
module crtc_timing #(
    parameter int H_WIDTH  = 8,
    parameter int V_WIDTH  = 7,
    parameter int RA_WIDTH = 5,
    parameter int MA_WIDTH = 14
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cclk_en_i,
    input  logic [3:0]          reg_addr_i,
    input  logic [7:0]          reg_data_i,
    input  logic                reg_we_i,
    output logic [7:0]          reg_data_o,
    output logic                h_sync_o,
    output logic                v_sync_o,
    output logic                de_o,
    output logic [MA_WIDTH-1:0] ma_o,
    output logic [RA_WIDTH-1:0] ra_o,
    output logic                cursor_o,
    output logic                frame_o
);

    typedef enum logic {ROWS, ADJUST} vstate_t;

    logic [7:0]          regs [16];
    vstate_t             state;
    logic [H_WIDTH-1:0]  h;
    logic [V_WIDTH-1:0]  row;
    logic [RA_WIDTH-1:0] ra;
    logic [MA_WIDTH-1:0] row_start;
    logic [4:0]          hs_rem;
    logic [4:0]          vs_lines;
    logic [4:0]          blink;

    logic [H_WIDTH-1:0]  r_htot, r_hdisp, r_hsync;
    logic [V_WIDTH-1:0]  r_vtot, r_vdisp, r_vsync;
    logic [RA_WIDTH-1:0] r_max_ra, r_adj, r_cur_lo, r_cur_hi;
    logic [MA_WIDTH-1:0] r_start, r_cursor, ma_cur;
    logic [4:0]          hs_w, vs_w, vs_n;

    logic line_end, last_ra, adj_last, frame_end;
    logic de_cur, hs_start, hs_cur, vs_trig, vs_cur;
    logic blink_on, cur_cur, first;
    logic unused_ok;

    assign r_htot   = H_WIDTH'(regs[0]);
    assign r_hdisp  = H_WIDTH'(regs[1]);
    assign r_hsync  = H_WIDTH'(regs[2]);
    assign r_vtot   = V_WIDTH'(regs[4][6:0]);
    assign r_vdisp  = V_WIDTH'(regs[6][6:0]);
    assign r_vsync  = V_WIDTH'(regs[7][6:0]);
    assign r_adj    = RA_WIDTH'(regs[5][4:0]);
    assign r_max_ra = RA_WIDTH'(regs[9][4:0]);
    assign r_cur_lo = RA_WIDTH'(regs[10][4:0]);
    assign r_cur_hi = RA_WIDTH'(regs[11][4:0]);
    assign r_start  = MA_WIDTH'({regs[12][5:0], regs[13]});
    assign r_cursor = MA_WIDTH'({regs[14][5:0], regs[15]});

    // A zero width field means 16
    assign hs_w = {regs[3][3:0] == 4'd0, regs[3][3:0]};
    assign vs_w = {regs[3][7:4] == 4'd0, regs[3][7:4]};

    assign unused_ok = ^{regs[4][7], regs[5][7:5], regs[6][7],
                         regs[7][7], regs[8], regs[9][7:5],
                         regs[10][7], regs[11][7:5], regs[12][7:6]};

    assign reg_data_o = (reg_addr_i == 4'd14) ? regs[14] :
                        (reg_addr_i == 4'd15) ? regs[15] : 8'h00;

    assign line_end = (h == r_htot);
    assign last_ra  = (ra == r_max_ra);
    assign adj_last = (RA_WIDTH'(ra + 1'b1) == r_adj);

    assign frame_end = line_end &&
        ((state == ROWS && last_ra && row == r_vtot && r_adj == '0) ||
         (state == ADJUST && adj_last));

    assign de_cur   = (h < r_hdisp) && (state == ROWS) && (row < r_vdisp);
    assign ma_cur   = row_start + MA_WIDTH'(h);
    assign hs_start = (h == r_hsync);
    assign hs_cur   = hs_start || (hs_rem != '0);
    assign vs_trig  = (state == ROWS) && (h == '0) && (row == r_vsync) &&
                      (ra == '0);
    assign vs_cur   = vs_trig || (vs_lines != '0);
    assign first    = (state == ROWS) && (h == '0) && (row == '0) &&
                      (ra == '0);

    always_comb begin
        vs_n = vs_trig ? vs_w : vs_lines;
        if (line_end && vs_n != '0)
            vs_n = vs_n - 5'd1;
    end

    always_comb begin
        blink_on = 1'b1;
        unique case (regs[10][6:5])
            2'b00: blink_on = 1'b1;
            2'b01: blink_on = 1'b0;
            2'b10: blink_on = blink[3];
            2'b11: blink_on = blink[4];
        endcase
    end

    assign cur_cur = de_cur && (ma_cur == r_cursor) && blink_on &&
                     (r_cur_lo <= ra) && (ra <= r_cur_hi);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else if (reg_we_i) begin
            regs[reg_addr_i] <= reg_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ROWS;
            h         <= '0;
            row       <= '0;
            ra        <= '0;
            row_start <= '0;
            hs_rem    <= '0;
            vs_lines  <= '0;
            blink     <= '0;
            h_sync_o  <= 1'b0;
            v_sync_o  <= 1'b0;
            de_o      <= 1'b0;
            ma_o      <= '0;
            ra_o      <= '0;
            cursor_o  <= 1'b0;
            frame_o   <= 1'b0;
        end else begin
            frame_o <= cclk_en_i && first;
            if (cclk_en_i) begin
                h_sync_o <= hs_cur;
                v_sync_o <= vs_cur;
                de_o     <= de_cur;
                ma_o     <= ma_cur;
                ra_o     <= ra;
                cursor_o <= cur_cur;

                h <= line_end ? '0 : h + 1'b1;
                if (hs_start)
                    hs_rem <= hs_w - 5'd1;
                else if (hs_rem != '0)
                    hs_rem <= hs_rem - 5'd1;
                vs_lines <= vs_n;

                if (line_end) begin
                    unique case (state)
                        ROWS: begin
                            if (last_ra) begin
                                ra        <= '0;
                                row_start <= row_start +
                                             MA_WIDTH'(r_hdisp);
                                if (row == r_vtot) begin
                                    if (r_adj != '0)
                                        state <= ADJUST;
                                end else begin
                                    row <= row + 1'b1;
                                end
                            end else begin
                                ra <= ra + 1'b1;
                            end
                        end
                        ADJUST: ra <= ra + 1'b1;
                    endcase
                end

                if (frame_end) begin
                    state     <= ROWS;
                    row       <= '0;
                    ra        <= '0;
                    row_start <= r_start;
                    blink     <= blink + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crtc_timing.sv
// Directed bench for crtc_timing: sync/DE/MA/RA sequencing, cursor
// blink modes, MA wrap, wide h_sync, no-adjust frames and async reset.
module tb_crtc_timing;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cclk_en;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        hs, vs, de, cur, frm;
    logic [13:0] ma;
    logic [4:0]  ra;

    logic        s_hs, s_vs, s_de, s_cur, s_frm;
    logic [13:0] s_ma;
    logic [4:0]  s_ra;

    int n_chk  = 0;
    int n_fail = 0;

    crtc_timing dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .cclk_en_i  (cclk_en),
        .reg_addr_i (addr),
        .reg_data_i (wdata),
        .reg_we_i   (we),
        .reg_data_o (rdata),
        .h_sync_o   (hs),
        .v_sync_o   (vs),
        .de_o       (de),
        .ma_o       (ma),
        .ra_o       (ra),
        .cursor_o   (cur),
        .frame_o    (frm)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One character: enable high for one clk out of every four
    task automatic tick();
        @(negedge clk);
        cclk_en = 1'b1;
        @(negedge clk);
        cclk_en = 1'b0;
        s_hs  = hs;
        s_vs  = vs;
        s_de  = de;
        s_cur = cur;
        s_frm = frm;
        s_ma  = ma;
        s_ra  = ra;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        addr  = 4'(a);
        wdata = 8'(d);
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic prog_base();
        wr(0, 5);  wr(1, 3);  wr(2, 4);  wr(3, 8'h11);
        wr(4, 4);  wr(5, 2);  wr(6, 2);  wr(7, 3);
        wr(9, 2);  wr(10, 8'h20);
    endtask

    task automatic run_to_frame();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_frm && k < 1000);
        check("frame_found", 32'(s_frm), 1);
    endtask

    // Two frame starts so that frame-latched registers are in force
    task automatic settle();
        run_to_frame();
        run_to_frame();
    endtask

    // Base config: 6-char lines, 5 rows x 3 scanlines + 2 adjust lines
    function automatic logic [23:0] model(input int i);
        int line, h, row, r, m;
        line = i / 6;
        h    = i % 6;
        row  = (line < 15) ? line / 3 : 5;
        r    = (line < 15) ? line % 3 : line - 15;
        m    = row * 3 + h;
        return {1'b0, i == 0, h == 4, line == 9,
                line < 6 && h < 3, 5'(r), 14'(m)};
    endfunction

    task automatic check_frames(input int nf);
        for (int i = 0; i < nf * 102; i++) begin
            tick();
            check($sformatf("vec%0d", i),
                  32'({s_cur, s_frm, s_hs, s_vs, s_de, s_ra, s_ma}),
                  32'(model(i % 102)));
        end
    endtask

    // Starts on a frame-start sample, ends on the next one
    task automatic scan_frame(output int n, output int cn,
                              output int hn, output int vn,
                              output int dn, output int hrun,
                              output int cpos);
        int run;
        n = 0; cn = 0; hn = 0; vn = 0; dn = 0;
        hrun = 0; cpos = -1; run = 0;
        do begin
            if (s_cur) begin
                if (cn == 0) cpos = n;
                cn++;
            end
            hn += int'(s_hs);
            vn += int'(s_vs);
            dn += int'(s_de);
            run = s_hs ? run + 1 : 0;
            if (run > hrun) hrun = run;
            tick();
            n++;
        end while (!s_frm && n < 1000);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_hs"},  32'(hs),  0);
        check({tag, "_vs"},  32'(vs),  0);
        check({tag, "_de"},  32'(de),  0);
        check({tag, "_ma"},  32'(ma),  0);
        check({tag, "_ra"},  32'(ra),  0);
        check({tag, "_cur"}, 32'(cur), 0);
        check({tag, "_frm"}, 32'(frm), 0);
        check({tag, "_rd"},  32'(rdata), 0);
    endtask

    initial begin
        int n, cn, hn, vn, dn, hrun, cpos, on_frames, k;

        reset_i = 1'b1;
        cclk_en = 1'b0;
        addr    = 4'd15;
        wdata   = 8'h00;
        we      = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset_i = 1'b0;

        // Base timing, two full frames char by char
        prog_base();
        check_frames(2);
        tick();
        check("frame_start", 32'(s_frm), 1);
        check("frame_pulse_1clk", 32'(frm), 0);
        scan_frame(n, cn, hn, vn, dn, hrun, cpos);
        check("frame_len", 32'(n), 102);
        check("de_count", 32'(dn), 18);
        check("vs_count", 32'(vn), 6);
        check("hs_count", 32'(hn), 17);
        check("hs_width", 32'(hrun), 1);

        // Start address wraps at 14 bits
        wr(12, 8'h3F);
        wr(13, 8'hFE);
        settle();
        check("ma_r0_h0", 32'(s_ma), 32'h3FFE);
        tick();
        check("ma_r0_h1", 32'(s_ma), 32'h3FFF);
        tick();
        check("ma_r0_h2", 32'(s_ma), 32'h0000);
        tick();
        check("ma_r0_h3", 32'(s_ma), 32'h0001);
        for (int i = 4; i <= 18; i++) tick();
        check("ma_r1_h0", 32'(s_ma), 32'h0001);
        check("ra_r1_h0", 32'(s_ra), 0);

        // Steady cursor at MA 4, scanline 1
        wr(12, 0);
        wr(13, 0);
        wr(14, 0);
        wr(15, 4);
        wr(10, 8'h01);
        wr(11, 8'h01);
        addr = 4'd15;
        #1 check("rd_r15", 32'(rdata), 4);
        addr = 4'd3;
        #1 check("rd_r3", 32'(rdata), 0);
        settle();
        scan_frame(n, cn, hn, vn, dn, hrun, cpos);
        check("cur_steady_cnt", 32'(cn), 1);
        check("cur_steady_pos", 32'(cpos), 25);

        wr(10, 8'h21);
        settle();
        scan_frame(n, cn, hn, vn, dn, hrun, cpos);
        check("cur_off_cnt", 32'(cn), 0);

        wr(10, 8'h41);
        settle();
        on_frames = 0;
        for (int f = 0; f < 16; f++) begin
            scan_frame(n, cn, hn, vn, dn, hrun, cpos);
            if (cn > 0) on_frames++;
        end
        check("blink16_on", 32'(on_frames), 8);

        wr(10, 8'h61);
        settle();
        on_frames = 0;
        for (int f = 0; f < 32; f++) begin
            scan_frame(n, cn, hn, vn, dn, hrun, cpos);
            if (cn > 0) on_frames++;
        end
        check("blink32_on", 32'(on_frames), 16);

        // 16-char h_sync, no adjust lines
        wr(10, 8'h20);
        wr(3, 8'h00);
        wr(0, 20);
        wr(5, 0);
        settle();
        scan_frame(n, cn, hn, vn, dn, hrun, cpos);
        check("noadj_frame_len", 32'(n), 315);
        check("hs16_count", 32'(hn), 240);
        check("hs16_width", 32'(hrun), 16);
        check("noadj_de", 32'(dn), 18);

        // Async reset in the middle of v_sync
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_vs && k < 400);
        check("vs_seen", 32'(s_vs), 1);
        addr = 4'd15;
        #2 reset_i = 1'b1;
        #1 check_idle("async");
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        prog_base();
        check_frames(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
